// File: rtl/rs_int_bank.sv
// rs_int_bank: integer reservation station with CDB wakeup/bypass and oldest-ready issue; write_en to issue_valid is 2 edges (1 with RS_INT_FAST_ISSUE_EN).
// Backpressure: the issue register holds while issue_ready=0; write_en while full is dropped.
`ifndef ROB_ADDR_BUS
`define ROB_ADDR_BUS 4:0
`endif
`ifndef OPGEN_BUS
`define OPGEN_BUS 5:0
`endif
`ifndef DATA_BUS
`define DATA_BUS 31:0
`endif

module rs_int_bank #(
  parameter int ENTRY_NUM = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 write_en,
  output logic                 full,
  input  logic [`ROB_ADDR_BUS] rob_addr_in,
  input  logic [`OPGEN_BUS]    opgen_in,
  input  logic                 operand_is_ref_1_in,
  input  logic                 operand_is_ref_2_in,
  input  logic [`DATA_BUS]     operand_data_1_in,
  input  logic [`DATA_BUS]     operand_data_2_in,
  input  logic                 bus_en,
  input  logic [`DATA_BUS]     bus_ref_id_in,
  input  logic [`DATA_BUS]     bus_data_in,
  output logic                 issue_valid,
  input  logic                 issue_ready,
  output logic [`ROB_ADDR_BUS] issue_rob_addr,
  output logic [`OPGEN_BUS]    issue_opgen,
  output logic [`DATA_BUS]     issue_operand_1,
  output logic [`DATA_BUS]     issue_operand_2
);
  localparam int IDX_W = $clog2(ENTRY_NUM);

  logic [ENTRY_NUM-1:0] valid;
  logic [ENTRY_NUM-1:0] is_ref_1;
  logic [ENTRY_NUM-1:0] is_ref_2;
  logic [`ROB_ADDR_BUS] rob_addr [ENTRY_NUM];
  logic [`OPGEN_BUS]    opgen    [ENTRY_NUM];
  logic [`DATA_BUS]     data_1   [ENTRY_NUM];
  logic [`DATA_BUS]     data_2   [ENTRY_NUM];
  // older[i][j] set means entry i was allocated before entry j
  logic [ENTRY_NUM-1:0] older    [ENTRY_NUM];

  logic [ENTRY_NUM-1:0] ready;
  logic [ENTRY_NUM-1:0] sel_oh;
  logic [IDX_W-1:0]     sel_idx;
  logic [IDX_W-1:0]     alloc_idx;
  logic                 any_ready;
  logic                 take;
  logic                 issue_load;
  logic                 fast_issue;
  logic                 do_alloc;
  logic                 hit_1;
  logic                 hit_2;
  logic                 in_ref_1;
  logic                 in_ref_2;
  logic [`DATA_BUS]     in_data_1;
  logic [`DATA_BUS]     in_data_2;

  always_comb begin
    hit_1     = bus_en && operand_is_ref_1_in && (operand_data_1_in == bus_ref_id_in);
    hit_2     = bus_en && operand_is_ref_2_in && (operand_data_2_in == bus_ref_id_in);
    in_ref_1  = operand_is_ref_1_in && !hit_1;
    in_ref_2  = operand_is_ref_2_in && !hit_2;
    in_data_1 = hit_1 ? bus_data_in : operand_data_1_in;
    in_data_2 = hit_2 ? bus_data_in : operand_data_2_in;

    full      = &valid;
    ready     = valid & ~is_ref_1 & ~is_ref_2;
    any_ready = |ready;

    sel_oh = ready;
    for (int i = 0; i < ENTRY_NUM; i++) begin
      for (int j = 0; j < ENTRY_NUM; j++) begin
        if (j != i && ready[j] && older[j][i]) sel_oh[i] = 1'b0;
      end
    end
    sel_idx = '0;
    for (int i = 0; i < ENTRY_NUM; i++) begin
      if (sel_oh[i]) sel_idx = IDX_W'(i);
    end
    alloc_idx = '0;
    for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
      if (!valid[i]) alloc_idx = IDX_W'(i);
    end

    take       = !issue_valid || issue_ready;
    issue_load = take && any_ready;
`ifdef RS_INT_FAST_ISSUE_EN
    fast_issue = write_en && !full && !in_ref_1 && !in_ref_2 && !any_ready && take;
`else
    fast_issue = 1'b0;
`endif
    do_alloc = write_en && !full && !fast_issue;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid    <= '0;
      is_ref_1 <= '0;
      is_ref_2 <= '0;
      for (int i = 0; i < ENTRY_NUM; i++) begin
        older[i]    <= '0;
        rob_addr[i] <= '0;
        opgen[i]    <= '0;
        data_1[i]   <= '0;
        data_2[i]   <= '0;
      end
    end else if (flush) begin
      valid <= '0;
    end else begin
      if (bus_en) begin
        for (int i = 0; i < ENTRY_NUM; i++) begin
          if (valid[i] && is_ref_1[i] && data_1[i] == bus_ref_id_in) begin
            is_ref_1[i] <= 1'b0;
            data_1[i]   <= bus_data_in;
          end
          if (valid[i] && is_ref_2[i] && data_2[i] == bus_ref_id_in) begin
            is_ref_2[i] <= 1'b0;
            data_2[i]   <= bus_data_in;
          end
        end
      end
      if (issue_load) valid[sel_idx] <= 1'b0;
      // the allocated slot was free pre-edge, so it never collides with the freed one
      if (do_alloc) begin
        valid[alloc_idx]    <= 1'b1;
        rob_addr[alloc_idx] <= rob_addr_in;
        opgen[alloc_idx]    <= opgen_in;
        is_ref_1[alloc_idx] <= in_ref_1;
        is_ref_2[alloc_idx] <= in_ref_2;
        data_1[alloc_idx]   <= in_data_1;
        data_2[alloc_idx]   <= in_data_2;
        for (int j = 0; j < ENTRY_NUM; j++) older[j][alloc_idx] <= 1'b1;
        older[alloc_idx] <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      issue_valid     <= 1'b0;
      issue_rob_addr  <= '0;
      issue_opgen     <= '0;
      issue_operand_1 <= '0;
      issue_operand_2 <= '0;
    end else if (flush) begin
      issue_valid <= 1'b0;
    end else if (take) begin
      if (any_ready) begin
        issue_valid     <= 1'b1;
        issue_rob_addr  <= rob_addr[sel_idx];
        issue_opgen     <= opgen[sel_idx];
        issue_operand_1 <= data_1[sel_idx];
        issue_operand_2 <= data_2[sel_idx];
      end else if (fast_issue) begin
        issue_valid     <= 1'b1;
        issue_rob_addr  <= rob_addr_in;
        issue_opgen     <= opgen_in;
        issue_operand_1 <= in_data_1;
        issue_operand_2 <= in_data_2;
      end else begin
        issue_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rs_int_bank.sv
// Directed bench for rs_int_bank (default build): vector table plus multi-cycle sequences.
`ifndef ROB_ADDR_BUS
`define ROB_ADDR_BUS 4:0
`endif
`ifndef OPGEN_BUS
`define OPGEN_BUS 5:0
`endif
`ifndef DATA_BUS
`define DATA_BUS 31:0
`endif

module tb_rs_int_bank;
  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 flush = 1'b0;
  logic                 write_en = 1'b0;
  logic                 full;
  logic [`ROB_ADDR_BUS] rob_addr_in = '0;
  logic [`OPGEN_BUS]    opgen_in = '0;
  logic                 operand_is_ref_1_in = 1'b0;
  logic                 operand_is_ref_2_in = 1'b0;
  logic [`DATA_BUS]     operand_data_1_in = '0;
  logic [`DATA_BUS]     operand_data_2_in = '0;
  logic                 bus_en = 1'b0;
  logic [`DATA_BUS]     bus_ref_id_in = '0;
  logic [`DATA_BUS]     bus_data_in = '0;
  logic                 issue_valid;
  logic                 issue_ready = 1'b0;
  logic [`ROB_ADDR_BUS] issue_rob_addr;
  logic [`OPGEN_BUS]    issue_opgen;
  logic [`DATA_BUS]     issue_operand_1;
  logic [`DATA_BUS]     issue_operand_2;

  int checks = 0;
  int errors = 0;

  rs_int_bank #(.ENTRY_NUM(4)) dut (
    .clk(clk), .rst(rst), .flush(flush), .write_en(write_en), .full(full),
    .rob_addr_in(rob_addr_in), .opgen_in(opgen_in),
    .operand_is_ref_1_in(operand_is_ref_1_in), .operand_is_ref_2_in(operand_is_ref_2_in),
    .operand_data_1_in(operand_data_1_in), .operand_data_2_in(operand_data_2_in),
    .bus_en(bus_en), .bus_ref_id_in(bus_ref_id_in), .bus_data_in(bus_data_in),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_rob_addr(issue_rob_addr), .issue_opgen(issue_opgen),
    .issue_operand_1(issue_operand_1), .issue_operand_2(issue_operand_2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  rob;
    logic        r1;
    logic [31:0] d1;
    logic        r2;
    logic [31:0] d2;
    logic        be;
    logic [31:0] bid;
    logic [31:0] bdat;
    logic        rdy;
    logic        e_full;
    logic        e_iv;
    logic [4:0]  e_rob;
    logic [31:0] e_o1;
    logic [31:0] e_o2;
  } vec_t;

  vec_t tbl [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    write_en = 1'b0;
    bus_en   = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic wr(input logic [4:0] rob, input logic r1, input logic [31:0] d1,
                    input logic r2, input logic [31:0] d2);
    write_en            = 1'b1;
    rob_addr_in         = rob;
    opgen_in            = {1'b0, rob};
    operand_is_ref_1_in = r1;
    operand_data_1_in   = d1;
    operand_is_ref_2_in = r2;
    operand_data_2_in   = d2;
  endtask

  task automatic chk_issue(input string tag, input logic [4:0] rob,
                           input logic [31:0] o1, input logic [31:0] o2);
    chk({tag, " issue_valid"}, 32'(issue_valid), 32'd1);
    chk({tag, " rob"}, 32'(issue_rob_addr), 32'(rob));
    chk({tag, " opgen"}, 32'(issue_opgen), 32'({1'b0, rob}));
    chk({tag, " op1"}, issue_operand_1, o1);
    chk({tag, " op2"}, issue_operand_2, o2);
  endtask

  task automatic chk_empty(input string tag);
    chk({tag, " issue_valid"}, 32'(issue_valid), 32'd0);
    chk({tag, " full"}, 32'(full), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    //        we rob r1 d1     r2 d2     be bid    bdat   rdy full iv rob o1     o2
    tbl[0]  = '{1, 3, 0, 5,     0, 7,     0, 0,     0,     1,  0,   0, 0,  0,     0};
    tbl[1]  = '{0, 0, 0, 0,     0, 0,     0, 0,     0,     1,  0,   1, 3,  5,     7};
    tbl[2]  = '{0, 0, 0, 0,     0, 0,     0, 0,     0,     1,  0,   0, 0,  0,     0};
    tbl[3]  = '{1, 4, 1, 'h12,  1, 'h12,  0, 0,     0,     1,  0,   0, 0,  0,     0};
    tbl[4]  = '{0, 0, 0, 0,     0, 0,     0, 0,     0,     1,  0,   0, 0,  0,     0};
    tbl[5]  = '{0, 0, 0, 0,     0, 0,     1, 'h12,  'hAB,  1,  0,   0, 0,  0,     0};
    tbl[6]  = '{0, 0, 0, 0,     0, 0,     0, 0,     0,     1,  0,   1, 4,  'hAB,  'hAB};
    tbl[7]  = '{0, 0, 0, 0,     0, 0,     0, 0,     0,     1,  0,   0, 0,  0,     0};
    tbl[8]  = '{1, 5, 1, 'h20,  0, 2,     1, 'h20,  9,     1,  0,   0, 0,  0,     0};
    tbl[9]  = '{0, 0, 0, 0,     0, 0,     0, 0,     0,     1,  0,   1, 5,  9,     2};
    tbl[10] = '{0, 0, 0, 0,     0, 0,     0, 0,     0,     1,  0,   0, 0,  0,     0};
    tbl[11] = '{1, 6, 0, 'h61,  0, 'h62,  0, 0,     0,     1,  0,   0, 0,  0,     0};
    tbl[12] = '{1, 7, 0, 'h71,  0, 'h72,  0, 0,     0,     1,  0,   1, 6,  'h61,  'h62};
    tbl[13] = '{1, 8, 0, 'h81,  0, 'h82,  0, 0,     0,     1,  0,   1, 7,  'h71,  'h72};
    tbl[14] = '{0, 0, 0, 0,     0, 0,     0, 0,     0,     1,  0,   1, 8,  'h81,  'h82};
    tbl[15] = '{0, 0, 0, 0,     0, 0,     0, 0,     0,     1,  0,   0, 0,  0,     0};

    // reset values while rst is held low
    #12;
    chk("rst full", 32'(full), 32'd0);
    chk("rst issue_valid", 32'(issue_valid), 32'd0);
    chk("rst rob", 32'(issue_rob_addr), 32'd0);
    chk("rst opgen", 32'(issue_opgen), 32'd0);
    chk("rst op1", issue_operand_1, 32'd0);
    chk("rst op2", issue_operand_2, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    step();

    for (int k = 0; k < 16; k++) begin
      write_en            = tbl[k].we;
      rob_addr_in         = tbl[k].rob;
      opgen_in            = {1'b0, tbl[k].rob};
      operand_is_ref_1_in = tbl[k].r1;
      operand_data_1_in   = tbl[k].d1;
      operand_is_ref_2_in = tbl[k].r2;
      operand_data_2_in   = tbl[k].d2;
      bus_en              = tbl[k].be;
      bus_ref_id_in       = tbl[k].bid;
      bus_data_in         = tbl[k].bdat;
      issue_ready         = tbl[k].rdy;
      step();
      chk($sformatf("vec%0d full", k), 32'(full), 32'(tbl[k].e_full));
      chk($sformatf("vec%0d issue_valid", k), 32'(issue_valid), 32'(tbl[k].e_iv));
      if (tbl[k].e_iv) chk_issue($sformatf("vec%0d", k), tbl[k].e_rob, tbl[k].e_o1, tbl[k].e_o2);
    end
    idle();

    // full / drop / allocation order differing from index order
    issue_ready = 1'b1;
    wr(10, 1, 'h30, 0, 1);      step();
    wr(11, 0, 'h11, 0, 'h22);   step();
    wr(12, 1, 'h30, 0, 2);      step();
    chk_issue("ord_b", 11, 'h11, 'h22);
    wr(13, 1, 'h30, 0, 3);      step();
    chk("ord_b consumed", 32'(issue_valid), 32'd0);
    wr(14, 1, 'h30, 0, 4);      step();
    chk("ord full", 32'(full), 32'd1);
    wr(15, 0, 1, 0, 1);
    #1;
    chk("ord full comb", 32'(full), 32'd1);
    step();
    chk("ord drop full", 32'(full), 32'd1);
    chk("ord drop iv", 32'(issue_valid), 32'd0);
    idle();
    bus_en = 1'b1; bus_ref_id_in = 'h30; bus_data_in = 'h55;
    step();
    bus_en = 1'b0;
    chk("ord wake iv", 32'(issue_valid), 32'd0);
    step();
    chk_issue("ord_1", 10, 'h55, 1);
    chk("ord free full", 32'(full), 32'd0);
    step(); chk_issue("ord_2", 12, 'h55, 2);
    step(); chk_issue("ord_3", 13, 'h55, 3);
    step(); chk_issue("ord_4", 14, 'h55, 4);
    step(); chk_empty("ord_done");

    // stall with issue_ready low, then drain one per cycle
    issue_ready = 1'b0;
    wr(20, 0, 'h200, 0, 'h201); step();
    chk("stall first iv", 32'(issue_valid), 32'd0);
    wr(21, 0, 'h210, 0, 'h211); step();
    chk_issue("stall load", 20, 'h200, 'h201);
    wr(22, 0, 'h220, 0, 'h221); step();
    idle();
    for (int c = 0; c < 3; c++) begin
      step();
      chk_issue($sformatf("stall hold%0d", c), 20, 'h200, 'h201);
    end
    chk("stall full", 32'(full), 32'd0);
    issue_ready = 1'b1;
    step(); chk_issue("drain_1", 21, 'h210, 'h211);
    step(); chk_issue("drain_2", 22, 'h220, 'h221);
    step(); chk_empty("drain_done");

    // flush beats simultaneous write, wakeup and issue
    issue_ready = 1'b0;
    for (int n = 0; n < 4; n++) begin
      wr(5'(30 + n), 0, 32'(n), 0, 32'(n));
      step();
    end
    idle();
    chk_issue("pre_flush", 30, 0, 0);
    flush = 1'b1; issue_ready = 1'b1;
    wr(29, 0, 1, 0, 1);
    bus_en = 1'b1; bus_ref_id_in = 'h30;
    step();
    idle();
    chk_empty("flush");
    step(); chk_empty("flush+1");

    // asynchronous reset mid-stream with a full bank
    issue_ready = 1'b0;
    for (int n = 0; n < 5; n++) begin
      wr(5'(40 + n), 0, 32'(n + 1), 0, 32'(n + 2));
      step();
    end
    idle();
    chk("pre_rst full", 32'(full), 32'd1);
    chk_issue("pre_rst", 40, 1, 2);
    #3;
    rst = 1'b0;
    #1;
    chk_empty("async_rst");
    chk("async_rst rob", 32'(issue_rob_addr), 32'd0);
    chk("async_rst op1", issue_operand_1, 32'd0);
    issue_ready = 1'b1;
    wr(45, 0, 7, 0, 8);
    bus_en = 1'b1;
    step(); step();
    chk_empty("in_rst");
    idle();
    rst = 1'b1;
    step(); step();
    chk_empty("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
